bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesting masters (2..16).
REQ-002 Parameter MAX_HOLD, default 16, maximum consecutive grant cycles before preemption; 0 disables preemption.
REQ-003 Parameter MODE, default 0, arbitration policy: 0 round-robin, 1 fixed priority (index 0 highest).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NUM_MASTERS  per-master bus request, level.
REQ-007 lock  input  NUM_MASTERS  per-master lock; exempts current owner from MAX_HOLD preemption.
REQ-008 gnt  output  NUM_MASTERS  registered one-hot grant; all-zero when idle.
REQ-009 gnt_id  output  max(1,clog2(NUM_MASTERS))  index of current owner; holds last owner when idle.
REQ-010 gnt_valid  output  1  high when any gnt bit is high.
REQ-011 arb_switch  output  1  one-cycle pulse in the first cycle of every new grant.

Function
REQ-012 Two states: IDLE (no grant) and GRANT (exactly one gnt bit high); gnt never has more than one bit set.
REQ-013 Latency: req sampled at edge k drives gnt from cycle k+1; no dead cycle between consecutive owners.
REQ-014 IDLE: no req -> stay IDLE; any req -> GRANT to winner per REQ-018/019, hold_cnt=1, arb_switch=1.
REQ-015 GRANT, owner o, req[o]=0: rearbitrate among remaining requesters; none -> IDLE, gnt=0 next cycle.
REQ-016 GRANT, req[o]=1, MAX_HOLD!=0, hold_cnt>=MAX_HOLD, lock[o]=0, any other req high: preempt, grant next winner excluding o.
REQ-017 Otherwise owner keeps grant; hold_cnt increments, saturating at MAX_HOLD; lock high keeps owner indefinitely.
REQ-018 MODE 0: winner is first requester searching from last_owner+1 upward, wrapping modulo NUM_MASTERS; last_owner updates on each new grant.
REQ-019 MODE 1: winner is lowest-index eligible requester; preemption and lock rules unchanged.
REQ-020 Simultaneous req drop by owner and raise by others at the same edge: handled as REQ-015, same-edge handover.
REQ-021 Owner regaining eligibility: a preempted master re-requesting is served only after the round-robin search reaches it (MODE 0).
REQ-022 hold_cnt width clog2(MAX_HOLD+1); internal only.
REQ-023 lock on a non-owner has no effect.

Reset
REQ-024 On rst: state IDLE, gnt=0, gnt_valid=0, arb_switch=0, gnt_id=0, hold_cnt=0, last_owner=NUM_MASTERS-1 so master 0 wins first RR search.
REQ-025 rst asserted mid-grant drops gnt at the next edge irrespective of req/lock; arbitration resumes the cycle after rst deasserts.

Structure
REQ-026 MODE encodings (ARB_MODE_RR, ARB_MODE_FIXED) and YES/NO levels live in the shared defines file.
REQ-027 One sub-module arb_pick: combinational masked rotating priority encoder (inputs req, exclude mask, start index, mode; outputs winner index, found).
REQ-028 All state in one clocked process in bus_arbiter; outputs driven directly from registers.

Verification
REQ-029 Reset release, req=4'b0101, MODE 0: gnt=0001 at cycle 1; drop req[0] -> gnt=0100 next cycle, arb_switch pulses each change.
REQ-030 MODE 0, MAX_HOLD=4, req=1111 constant, lock=0: grant rotates 0,1,2,3,0 each exactly 4 cycles.
REQ-031 Same as REQ-030 with lock[1]=1: master 1 holds grant 20 cycles until lock drops, then master 2 granted next cycle.
REQ-032 MODE 1, MAX_HOLD=0, req=1110 then req[0] raised while master 1 owns: master 1 retains until req[1] drops, then master 0.
REQ-033 Only master 2 requests, MAX_HOLD=4: grant held 10 cycles uninterrupted (no preemption without competitor); drop -> gnt=0, gnt_valid=0.
REQ-034 rst pulsed while master 3 owns with lock[3]=1: gnt=0 next cycle; after release with req=1000, gnt=1000 one cycle later.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared encodings, levels and state type for the bus arbiter
package bus_arbiter_pkg;
    localparam int ARB_MODE_RR = 0;
    localparam int ARB_MODE_FIXED = 1;
    localparam logic YES = 1'b1;
    localparam logic NO = 1'b0;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bus_arbiter_arb_pick.sv
// arb_pick: masked rotating priority encoder; fixed mode always scans from index 0
module arb_pick
    import bus_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  excl,
    input  logic [IW-1:0] start,
    input  logic          mode,
    output logic [IW-1:0] winner,
    output logic          found
);
    logic [N-1:0] cand;
    assign cand = req & ~excl;
    // scan offsets from farthest to nearest so the nearest candidate is written last
    always_comb begin
        logic [IW-1:0] idx;
        int base;
        idx = '0;
        base = mode ? 0 : int'(start);
        winner = '0;
        found = NO;
        for (int i = N - 1; i >= 0; i--) begin
            idx = IW'((base + i) % N);
            if (cand[idx]) begin
                winner = idx;
                found = YES;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: registered one-hot bus arbiter with round-robin/fixed priority and hold-limit preemption
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD = 16,
    parameter int MODE = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_MASTERS-1:0]              req,
    input  logic [NUM_MASTERS-1:0]              lock,
    output logic [NUM_MASTERS-1:0]              gnt,
    output logic [idx_width(NUM_MASTERS)-1:0]   gnt_id,
    output logic                                gnt_valid,
    output logic                                arb_switch
);
    localparam int IW = idx_width(NUM_MASTERS);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);
    arb_state_t state;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] last_owner, start, winner;
    logic found, owner_req, preempt, take, drop;
    assign start = (last_owner == LAST_IDX) ? '0 : last_owner + 1'b1;
    assign owner_req = |(req & gnt);
    assign preempt = (MAX_HOLD != 0) && (hold_cnt >= HOLD_MAX) && !(|(lock & gnt)) && (|(req & ~gnt));
    assign take = found && (state == IDLE || !owner_req || preempt);
    assign drop = (state == GRANT) && !owner_req && !found;
    // the current owner is excluded from the search; gnt is all-zero when idle
    arb_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .req(req),
        .excl(gnt),
        .start(start),
        .mode(MODE == ARB_MODE_FIXED),
        .winner(winner),
        .found(found)
    );
    // grant state: new grants, release to idle, and saturating hold count
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            gnt_id <= '0;
            gnt_valid <= NO;
            arb_switch <= NO;
            hold_cnt <= '0;
            last_owner <= LAST_IDX;
        end else begin
            arb_switch <= NO;
            if (take) begin
                state <= GRANT;
                gnt <= NUM_MASTERS'(1) << winner;
                gnt_id <= winner;
                gnt_valid <= YES;
                arb_switch <= YES;
                hold_cnt <= HW'(1);
                last_owner <= winner;
            end else if (drop) begin
                state <= IDLE;
                gnt <= '0;
                gnt_valid <= NO;
            end else if (state == GRANT) begin
                hold_cnt <= (hold_cnt < HOLD_MAX) ? hold_cnt + 1'b1 : hold_cnt;
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios checked against an integer-level arbitration model
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req_a = '0, lock_a = '0, req_b = '0, lock_b = '0;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic val_a, val_b, sw_a, sw_b;
    int n_cmp = 0;
    int n_bad = 0;
    bit live = 0;
    int own [2];
    int lst [2];
    int hold [2];
    int mid [2];
    bit msw [2];

    always #5 clk = ~clk;

    bus_arbiter #(.NUM_MASTERS(4), .MAX_HOLD(4), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .lock(lock_a),
        .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(val_a), .arb_switch(sw_a)
    );
    bus_arbiter #(.NUM_MASTERS(4), .MAX_HOLD(0), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .lock(lock_b),
        .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(val_b), .arb_switch(sw_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick_m(input bit fixed, input logic [3:0] r, input int excl, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = fixed ? k - 1 : (last + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic step(input int j, input logic [3:0] r, input logic [3:0] l, input bit fixed, input int mh);
        int nxt;
        if (rst) begin
            own[j] = -1; mid[j] = 0; lst[j] = 3; hold[j] = 0; msw[j] = 0;
            return;
        end
        nxt = own[j];
        if (own[j] < 0)
            nxt = pick_m(fixed, r, -1, lst[j]);
        else if (!r[own[j]] || (mh != 0 && hold[j] >= mh && !l[own[j]] && (r & ~(4'b1 << own[j])) != 4'b0))
            nxt = pick_m(fixed, r, own[j], lst[j]);
        msw[j] = (nxt >= 0) && (nxt != own[j]);
        if (msw[j]) begin
            hold[j] = 1; lst[j] = nxt; mid[j] = nxt;
        end else if (nxt >= 0) begin
            hold[j] = (hold[j] < mh) ? hold[j] + 1 : hold[j];
        end
        own[j] = nxt;
    endtask

    always @(posedge clk) begin
        step(0, req_a, lock_a, 1'b0, 4);
        step(1, req_b, lock_b, 1'b1, 0);
        if (rst) live = 1;
    end

    always @(negedge clk) begin
        if (live) begin
            check("a_gnt", gnt_a, own[0] < 0 ? 0 : 1 << own[0]);
            check("a_id", id_a, mid[0]);
            check("a_valid", val_a, own[0] >= 0);
            check("a_switch", sw_a, msw[0]);
            check("b_gnt", gnt_b, own[1] < 0 ? 0 : 1 << own[1]);
            check("b_id", id_b, mid[1]);
            check("b_valid", val_b, own[1] >= 0);
            check("b_switch", sw_b, msw[1]);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_a = '0; lock_a = '0; req_b = '0; lock_b = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt_a, 0);
        check("rst_id", id_a, 0);
        check("rst_valid", val_a, 0);
        check("rst_switch", sw_a, 0);
        rst = 1'b0;
        req_a = 4'b0101;
        @(negedge clk);
        check("first_gnt", gnt_a, 4'b0001);
        check("first_switch", sw_a, 1);
        req_a = 4'b0100;
        @(negedge clk);
        check("handover_gnt", gnt_a, 4'b0100);
        check("handover_switch", sw_a, 1);
        check("handover_id", id_a, 2);
        @(negedge clk);
        check("steady_switch", sw_a, 0);
        req_a = 4'b0000;
        @(negedge clk);
        check("idle_gnt", gnt_a, 0);
        check("idle_valid", val_a, 0);
        check("idle_id_held", id_a, 2);

        do_reset();
        req_a = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("rotate_id", id_a, (k / 4) % 4);
            check("rotate_switch", sw_a, k % 4 == 0);
        end

        do_reset();
        req_a = 4'b1111;
        lock_a = 4'b0010;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check("lock_id", id_a, k < 4 ? 0 : (k < 24 ? 1 : 2));
            if (k == 23) lock_a = 4'b0000;
        end
        check("unlock_switch", sw_a, 1);

        do_reset();
        req_a = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("solo_gnt", gnt_a, 4'b0100);
            check("solo_switch", sw_a, k == 0);
        end
        req_a = 4'b0000;
        @(negedge clk);
        check("solo_drop_gnt", gnt_a, 0);
        check("solo_drop_valid", val_a, 0);

        do_reset();
        req_a = 4'b1000;
        lock_a = 4'b1000;
        repeat (3) @(negedge clk);
        check("locked_gnt", gnt_a, 4'b1000);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_gnt", gnt_a, 0);
        check("midrst_valid", val_a, 0);
        check("midrst_id", id_a, 0);
        rst = 1'b0;
        @(negedge clk);
        check("resume_gnt", gnt_a, 4'b1000);
        check("resume_switch", sw_a, 1);

        do_reset();
        req_b = 4'b1110;
        @(negedge clk);
        check("fixed_first", gnt_b, 4'b0010);
        req_b = 4'b1111;
        repeat (5) begin
            @(negedge clk);
            check("fixed_retain", gnt_b, 4'b0010);
        end
        req_b = 4'b1101;
        @(negedge clk);
        check("fixed_next", gnt_b, 4'b0001);
        check("fixed_switch", sw_b, 1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
